dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory port (AddrMode/A/WD in, RD out, combinational read, byte-array write on posedge) between NUM_REQ requesters, e.g. core MEM stage (req 0) and loader/DMA (req 1).
- Round-robin, one access per cycle, valid/ready request handshake, registered 1-cycle response.
- Optional bus lock with idle timeout supports multi-access atomic sequences.
- Sits between requesters and data memory; the memory itself is unchanged.

Parameters:
DATA_WIDTH, 32, data width of WD/RD
ADDR_WIDTH, 32, address width
NUM_REQ, 2, number of requesters (supported 2..4)
LOCK_TIMEOUT, 16, idle cycles a lock owner may hold the port before forced release (>=1)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  request present, per requester
req_ready  out  NUM_REQ  request accepted this cycle (grant)
req_mode  in  NUM_REQ x 4  AddrMode code per requester
req_addr  in  NUM_REQ x ADDR_WIDTH  byte address
req_wdata  in  NUM_REQ x DATA_WIDTH  store data
req_lock  in  NUM_REQ  hold port after this access
rsp_valid  out  NUM_REQ  response pulse, one cycle after acceptance
rsp_rdata  out  NUM_REQ x DATA_WIDTH  load result (0 for stores)
mem_AddrMode  out  4  to data memory
mem_A  out  ADDR_WIDTH  to data memory
mem_WD  out  DATA_WIDTH  to data memory
mem_RD  in  DATA_WIDTH  from data memory
lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_rdata=0, lock_timeout=0, state=ARB, last_grant=NUM_REQ-1 (req 0 wins first), timeout counter=0. req_ready is combinational and 0 while rst=1.
- Mode classes: 0000-0100 load; 0101/0110/0111 store byte/half/word; 1000-1111 treated as load word (no write), still acknowledged.
- ARB state: grant = first valid requester searching from last_grant+1 with wrap-around. At most one req_ready high. Combinational ready, no bubbles.
- Granted cycle: mem_AddrMode/mem_A/mem_WD = grantee's fields; the store commits at that posedge.
- No grant: mem_AddrMode=4'b0010 (load word, never a store), mem_A=0, mem_WD=0. Stores can never occur without a grant.
- Response: cycle after acceptance, rsp_valid[g]=1 for exactly one cycle. rsp_rdata[g]=mem_RD registered (loads) or 0 (stores). rsp_rdata of other requesters holds its value. Latency is fixed at 1; back-to-back grants give back-to-back responses.
- last_grant updates only on acceptance.
- Lock FSM, states ARB and LOCKED(owner):
  - ARB -> LOCKED: accepted request with req_lock=1; owner=grantee.
  - In LOCKED, only owner may be granted; others see ready=0 and stall.
  - An accepted owner request with req_lock=0 performs its access and returns to ARB. last_grant=owner, so the next requester rotates in.
  - Accepted owner requests with req_lock=1 stay LOCKED and clear the counter.
  - Counter increments each LOCKED cycle without owner req_valid. On reaching LOCK_TIMEOUT it returns to ARB, pulses lock_timeout for 1 cycle and clears the counter.
  - Same-cycle owner request and timeout: the request wins; the counter clears and there is no timeout.
- Read-after-write: store accepted cycle N, load same address accepted N+1 returns new data, because the memory write lands at the N edge.
- Requesters must hold req_* stable while valid and not ready; the arbiter does not buffer requests.
- Reset mid-access: a pending rsp_valid is dropped; a store already clocked is not undone.

Decomposition:
- Package dmem_arb_pkg holds:
  - mode constants LB=0000, LH=0001, LW=0010, LBU=0011, LHU=0100, SB=0101, SH=0110, SW=0111, IDLE_MODE=LW
  - function is_store(mode)
  - typedef enum logic {ARB, LOCKED} arb_state_t
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, last_grant -> one-hot grant, index).

Test Plan:
- Req0 SW addr 0x10000 wdata 0xDEADBEEF, then LW 0x10000 -> req_ready0 both cycles; rsp_valid0 in the cycle after each acceptance; second rsp_rdata0=0xDEADBEEF, first 0.
- Both valid continuously with LW to 0x10000/0x10004 -> grants alternate 0,1,0,1 starting with 0; each rsp_valid one cycle after its grant.
- Req1 LB at a byte 0x80 while req0 idle -> rsp_rdata1=0xFFFFFF80; LBU same address -> 0x00000080.
- Req0 lock=1 access, req1 valid throughout, req0 does 2 more locked accesses then lock=0 -> req1 ready=0 for all 4 req0 grants, then granted next cycle.
- Req0 lock=1 then idle, LOCK_TIMEOUT=16 -> lock_timeout pulses once, 16 cycles after entering LOCKED with no owner request; req1 granted the following cycle.
- No requests, or rst asserted mid-stream -> mem_AddrMode=0010, memory contents unchanged, all rsp_valid=0 during reset.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and mode encodings for the data-memory arbiter.
package dmem_arb_pkg;

  localparam logic [3:0] LB        = 4'b0000;
  localparam logic [3:0] LH        = 4'b0001;
  localparam logic [3:0] LW        = 4'b0010;
  localparam logic [3:0] LBU       = 4'b0011;
  localparam logic [3:0] LHU       = 4'b0100;
  localparam logic [3:0] SB        = 4'b0101;
  localparam logic [3:0] SH        = 4'b0110;
  localparam logic [3:0] SW        = 4'b0111;
  localparam logic [3:0] IDLE_MODE = LW;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  function automatic logic is_store(input logic [3:0] mode);
    return (mode == SB) || (mode == SH) || (mode == SW);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request after last_grant, with wrap-around.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last_grant) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port, with optional bus lock and idle timeout.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][3:0]               req_mode,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0]                    req_lock,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    rsp_rdata,
  output logic [3:0]                            mem_AddrMode,
  output logic [ADDR_WIDTH-1:0]                 mem_A,
  output logic [DATA_WIDTH-1:0]                 mem_WD,
  input  logic [DATA_WIDTH-1:0]                 mem_RD,
  output logic                                  lock_timeout
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t          state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       owner;
  logic [CW-1:0]       idle_cnt;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       gidx;
  logic                any;
  logic [3:0]          sel_mode;

  // While locked only the owner competes; nothing is eligible during reset.
  always_comb begin
    eligible = '0;
    if (!rst) begin
      if (state == LOCKED) eligible = req_valid & (NUM_REQ'(1) << owner);
      else                 eligible = req_valid;
    end
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req        (eligible),
    .last_grant (last_grant),
    .grant      (grant),
    .idx        (gidx),
    .any        (any)
  );

  assign req_ready = grant;
  assign sel_mode  = req_mode[gidx];

  // Idle port issues a harmless load word; reserved modes are forced to load word.
  always_comb begin
    mem_AddrMode = IDLE_MODE;
    mem_A        = '0;
    mem_WD       = '0;
    if (any) begin
      mem_AddrMode = sel_mode[3] ? LW : sel_mode;
      mem_A        = req_addr[gidx];
      mem_WD       = req_wdata[gidx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB;
      last_grant   <= IW'(NUM_REQ - 1);
      owner        <= '0;
      idle_cnt     <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      lock_timeout <= 1'b0;
    end else begin
      rsp_valid    <= '0;
      lock_timeout <= 1'b0;
      if (any) begin
        rsp_valid[gidx] <= 1'b1;
        rsp_rdata[gidx] <= is_store(sel_mode) ? '0 : mem_RD;
        last_grant      <= gidx;
        idle_cnt        <= '0;
        if (req_lock[gidx]) begin
          state <= LOCKED;
          owner <= gidx;
        end else begin
          state <= ARB;
        end
      end else if (state == LOCKED) begin
        // An owner access this cycle would have taken the branch above, so it beats the timeout.
        if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state        <= ARB;
          lock_timeout <= 1'b1;
          idle_cnt     <= '0;
        end else begin
          idle_cnt <= idle_cnt + CW'(1);
        end
      end
    end
  end

endmodule
